// File: rtl/regfile_debug_scanner.sv
// regfile_debug_scanner
//
// Walks the register file's debug read port and streams the register
// contents to a downstream consumer (UART formatter, display driver) over a
// valid/ready handshake. Everything runs on clock_debug.
//
// Modes (captured together with start):
//   single=0 : full dump, registers 0..NUM_REGS-1 in ascending order
//   single=1 : one register, single_addr
//
// Optional build macro REGDBG_CHECKSUM_EN:
//   When defined, a checksum word (XOR of every register word that was
//   transferred) follows the last register word. That word has out_is_csum=1,
//   out_index=0 and carries out_last instead of the final register word.
//   When undefined, out_is_csum is constant 0.
//
// Handshake: out_data/out_index/out_last/out_is_csum are meaningful while
// out_valid=1 and stay stable until a transfer, which happens on a posedge
// with out_valid=1 and out_ready=1. out_valid never drops without a transfer
// (reset excepted).
//
// Ports:
//   clock_debug  in   debug clock, posedge
//   reset        in   asynchronous, active-high
//   start        in   begin a scan (only looked at while idle)
//   single       in   1 = single-register read, 0 = full dump
//   single_addr  in   register for single mode
//   dbg_addr     out  register file read_address_debug (registered)
//   dbg_data     in   register file data_out_debug
//   out_valid    out  output word valid
//   out_ready    in   consumer accepts the word
//   out_data     out  register value (or checksum)
//   out_index    out  register index of out_data
//   out_last     out  final word of the scan
//   out_is_csum  out  word is the checksum
//   busy         out  scan in progress
//   done         out  one-cycle pulse after the final transfer
//   fsm_state    out  current FSM state (0 IDLE, 1 WAIT, 2 PRESENT, 3 FINISH)
module regfile_debug_scanner #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clock_debug,
    input  logic              reset,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] single_addr,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              out_is_csum,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    localparam int                CNT_W    = $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_idx;
    logic [ADDR_W-1:0] first_idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              xfer;
    logic              at_end;
    logic              capture;
    logic              advance;
    logic              final_xfer;

    assign fsm_state = state;
    assign xfer      = out_valid & out_ready;
    assign at_end    = (cur == end_idx);
    assign capture   = (state == S_WAIT) && (wait_cnt == CNT_ONE);
    assign first_idx = single ? single_addr : '0;

    // More registers to read after this word: reload the read pipeline.
    assign advance = (state == S_PRESENT) && xfer && !at_end;

`ifdef REGDBG_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              emit_csum;

    // The last register word is followed by the checksum word, so only the
    // checksum transfer ends the scan.
    assign emit_csum  = (state == S_PRESENT) && xfer && at_end && !out_is_csum;
    assign final_xfer = (state == S_PRESENT) && xfer && out_is_csum;
`else
    assign out_is_csum = 1'b0;
    assign final_xfer  = (state == S_PRESENT) && xfer && at_end;
`endif

    always_ff @(posedge clock_debug or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_WAIT;
            S_WAIT:    if (wait_cnt == CNT_ONE) state_next = S_PRESENT;
            S_PRESENT: begin
                if (final_xfer)   state_next = S_FINISH;
                else if (advance) state_next = S_WAIT;
            end
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_debug or posedge reset) begin
        if (reset) begin
            dbg_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur       <= '0;
            end_idx   <= '0;
            wait_cnt  <= '0;
`ifdef REGDBG_CHECKSUM_EN
            out_is_csum <= 1'b0;
            csum        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur      <= first_idx;
                        end_idx  <= single ? single_addr : LAST_IDX;
                        dbg_addr <= first_idx;
                        wait_cnt <= CNT_LOAD;
                        busy     <= 1'b1;
`ifdef REGDBG_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // dbg_addr was updated READ_LAT edges ago; the register
                    // file's registered read output is valid on this edge.
                    wait_cnt <= wait_cnt - CNT_ONE;
                    if (capture) begin
                        out_data  <= dbg_data;
                        out_index <= cur;
                        out_valid <= 1'b1;
`ifdef REGDBG_CHECKSUM_EN
                        out_last    <= 1'b0;
                        out_is_csum <= 1'b0;
`else
                        out_last    <= at_end;
`endif
                    end
                end
                S_PRESENT: begin
                    if (final_xfer) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (advance) begin
                        cur       <= cur + ADDR_ONE;
                        dbg_addr  <= cur + ADDR_ONE;
                        wait_cnt  <= CNT_LOAD;
                        out_valid <= 1'b0;
`ifdef REGDBG_CHECKSUM_EN
                        csum      <= csum ^ out_data;
`endif
                    end
`ifdef REGDBG_CHECKSUM_EN
                    else if (emit_csum) begin
                        // out_valid stays high: the checksum word follows
                        // the last register word without a gap.
                        out_data    <= csum ^ out_data;
                        out_index   <= '0;
                        out_is_csum <= 1'b1;
                        out_last    <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
